// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks both operands SLICE bits per cycle, MSB first,
// exiting on the first unequal slice. Define CMP_SIGNED_EN for a two's-complement compare.
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             clr_cnt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o,
    output logic [CNT_W-1:0] num_gt_o,
    output logic [CNT_W-1:0] num_lt_o,
    output logic [CNT_W-1:0] num_eq_o
);
    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   a_cap, b_cap;
    logic [SLICE-1:0]   sl_a, sl_b;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic               inc_gt, inc_lt, inc_eq;
    logic [CNT_W-1:0]   num_gt_q, num_gt_d, num_lt_q, num_lt_d, num_eq_q, num_eq_d;

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign a_cap = {~a_i[WIDTH-1], a_i[WIDTH-2:0]};
    assign b_cap = {~b_i[WIDTH-1], b_i[WIDTH-2:0]};
`else
    assign a_cap = a_i;
    assign b_cap = b_i;
`endif

    assign sl_a = a_sh_q[WIDTH-1 -: SLICE];
    assign sl_b = b_sh_q[WIDTH-1 -: SLICE];

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] q,
                                                  input logic inc, input logic clr);
        if (clr)
            return '0;
        else if (inc && !(&q))
            return q + CNT_W'(1);
        else
            return q;
    endfunction

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        inc_gt  = 1'b0;
        inc_lt  = 1'b0;
        inc_eq  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_cap;
                    b_sh_d  = b_cap;
                    idx_d   = '0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (sl_a != sl_b) begin
                    inc_gt  = (sl_a > sl_b);
                    inc_lt  = (sl_a < sl_b);
                    gt_d    = inc_gt;
                    lt_d    = inc_lt;
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    inc_eq  = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_sh_d = a_sh_q << SLICE;
                    b_sh_d = b_sh_q << SLICE;
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Clear wins over an increment landing on the same edge.
        num_gt_d = cnt_next(num_gt_q, inc_gt, clr_cnt_i);
        num_lt_d = cnt_next(num_lt_q, inc_lt, clr_cnt_i);
        num_eq_d = cnt_next(num_eq_q, inc_eq, clr_cnt_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            num_gt_q <= '0;
            num_lt_q <= '0;
            num_eq_q <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
            num_gt_q <= num_gt_d;
            num_lt_q <= num_lt_d;
            num_eq_q <= num_eq_d;
        end
    end

    assign busy_o   = (state_q == S_COMPARE);
    assign done_o   = (state_q == S_DONE);
    assign gt_o     = gt_q;
    assign lt_o     = lt_q;
    assign eq_o     = eq_q;
    assign num_gt_o = num_gt_q;
    assign num_lt_o = num_lt_q;
    assign num_eq_o = num_eq_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: an 8-bit-counter instance and a
// 2-bit-counter instance share all inputs so saturation is visible side by side.
module tb_serial_magnitude_comparator;
    logic        clk = 1'b0;
    logic        rst, start, clr_cnt;
    logic [15:0] a, b;
    logic        busy, done, gt, lt, eq;
    logic [7:0]  num_gt, num_lt, num_eq;
    logic        busy2, done2, gt2, lt2, eq2;
    logic [1:0]  num_gt2, num_lt2, num_eq2;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(16), .SLICE(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .clr_cnt_i(clr_cnt),
        .busy_o(busy), .done_o(done), .gt_o(gt), .lt_o(lt), .eq_o(eq),
        .num_gt_o(num_gt), .num_lt_o(num_lt), .num_eq_o(num_eq));

    serial_magnitude_comparator #(.WIDTH(16), .SLICE(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .clr_cnt_i(clr_cnt),
        .busy_o(busy2), .done_o(done2), .gt_o(gt2), .lt_o(lt2), .eq_o(eq2),
        .num_gt_o(num_gt2), .num_lt_o(num_lt2), .num_eq_o(num_eq2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
    endtask

    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input int exp_lat, input logic [2:0] exp_res);
        int k;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(k);
        check({tag, "_lat"}, k, exp_lat);
        check({tag, "_gle"}, {gt, lt, eq}, exp_res);
        tick();
    endtask

    initial begin
        int  k;
        logic seen_done;
        rst = 1'b1; start = 1'b0; clr_cnt = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_state", {busy, done, gt, lt, eq}, 5'b0);
        check("rst_cnt", {num_gt, num_lt, num_eq}, 24'h0);

        run_cmp("t1_eq", 16'h1234, 16'h1234, 4, 3'b001);
        check("t1_num_eq", num_eq, 1);
`ifdef CMP_SIGNED_EN
        run_cmp("t2_signed", 16'h8000, 16'h7FFF, 1, 3'b010);
`else
        run_cmp("t2_unsigned", 16'h8000, 16'h7FFF, 1, 3'b100);
`endif
        run_cmp("t3_last_lt", 16'h1230, 16'h1235, 4, 3'b010);
        run_cmp("t3_first_gt", 16'h2000, 16'h1FFF, 1, 3'b100);
`ifdef CMP_SIGNED_EN
        check("t3_cnt", {num_gt, num_lt, num_eq}, {8'd1, 8'd2, 8'd1});
`else
        check("t3_cnt", {num_gt, num_lt, num_eq}, {8'd2, 8'd1, 8'd1});
`endif

        // Reset during the second COMPARE cycle.
        a = 16'h1234; b = 16'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_gle", {gt, lt, eq}, 3'b000);
        check("t4_cnt", {num_gt, num_lt, num_eq}, 24'h0);
        check("t4_cnt_sat", {num_gt2, num_lt2, num_eq2}, 6'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_done |= done;
            tick();
        end
        check("t4_no_done", seen_done, 0);

        for (int i = 0; i < 5; i++)
            run_cmp("t5_gt", 16'h2000, 16'h1FFF, 1, 3'b100);
        check("t5_num_gt8", num_gt, 5);
        check("t5_num_gt2_sat", num_gt2, 3);
        check("t5_num_lt2", num_lt2, 0);

        // clr_cnt on the deciding edge of a sixth GT compare.
        a = 16'h2000; b = 16'h1FFF; start = 1'b1;
        tick();
        start = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t5_clr_done", done, 1);
        check("t5_clr_gt", {gt, lt, eq}, 3'b100);
        check("t5_clr_num8", num_gt, 0);
        check("t5_clr_num2", num_gt2, 0);
        tick();

        // start held high; operands change mid-compare.
        a = 16'd5; b = 16'd9; start = 1'b1;
        tick();
        a = 16'd9; b = 16'd5;
        wait_done(k);
        check("t6_lat1", k, 4);
        check("t6_res1", {gt, lt, eq}, 3'b010);
        tick();
        check("t6_idle_busy", busy, 0);
        tick();
        check("t6_restart_busy", busy, 1);
        start = 1'b0;
        wait_done(k);
        check("t6_lat2", k, 4);
        check("t6_res2", {gt, lt, eq}, 3'b100);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
